// File: rtl/logic_pipe.sv
// rtl/logic_pipe.sv - elastic pipelined bitwise logic unit (NOT/AND/OR/XOR/NOR/pass)
// Optional zero-result flag output enabled by LOGIC_PIPE_ZERO_FLAG_EN.
module logic_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    output logic             out_zero,
`endif
    output logic             illegal_op
);

    localparam logic [2:0] OP_NOT  = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_PASS = 3'b101;

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic              r_illegal;
    logic [STAGES-1:0] w_adv;
    logic              w_full_tail;
    logic [WIDTH-1:0]  w_result;
    logic              w_accept;
    logic              w_illegal;

    always_comb begin
        w_illegal = 1'b0;
        case (in_op)
            OP_NOT:  w_result = ~in_a;
            OP_AND:  w_result = in_a & in_b;
            OP_OR:   w_result = in_a | in_b;
            OP_XOR:  w_result = in_a ^ in_b;
            OP_NOR:  w_result = ~(in_a | in_b);
            OP_PASS: w_result = in_a;
            default: begin
                w_result  = '0;
                w_illegal = 1'b1;
            end
        endcase
    end

    // Stage k can move iff some stage at or after k is empty, or the consumer takes the tail.
    always_comb begin
        w_full_tail = 1'b1;
        w_adv       = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_full_tail = w_full_tail & r_valid[k];
            w_adv[k]    = out_ready | ~w_full_tail;
        end
    end

    assign in_ready = w_adv[0];
    assign w_accept = in_valid & w_adv[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_data[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                r_valid[0] <= in_valid;
                if (in_valid) begin
                    r_data[0] <= w_result;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k]) begin
                    r_valid[k] <= r_valid[k-1];
                    if (r_valid[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_illegal <= 1'b0;
        end else if (w_accept && w_illegal) begin
            r_illegal <= 1'b1;
        end
    end

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    logic [STAGES-1:0] r_zero;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_zero <= '0;
        end else begin
            if (w_accept) begin
                r_zero[0] <= (w_result == '0);
            end
            for (int k = 1; k < STAGES; k++) begin
                if (w_adv[k] && r_valid[k-1]) begin
                    r_zero[k] <= r_zero[k-1];
                end
            end
        end
    end

    assign out_zero = r_zero[STAGES-1];
`endif

    assign out_valid  = r_valid[STAGES-1];
    assign out_data   = r_data[STAGES-1];
    assign illegal_op = r_illegal;

endmodule

// File: tb/tb_logic_pipe.sv
// tb/tb_logic_pipe.sv - directed self-checking bench for logic_pipe
module tb_logic_pipe;

    localparam int WIDTH = 32;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    localparam int STAGES = 1;
`else
    localparam int STAGES = 2;
`endif

    logic             clk;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             illegal_op;
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    logic             out_zero;
`endif

    int checks = 0;
    int errors = 0;

    logic_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        .out_zero   (out_zero),
`endif
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_a = '0; in_b = '0; out_ready = 1'b1;
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal_op); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero got %b want 0", out_zero); end
`endif
        next_cycle();
        #2 reset_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_latency();
        out_ready = 1'b1; in_valid = 1'b1; in_op = 3'b000; in_a = 32'h0000FFFF; in_b = 32'h0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lat_in_ready got %b want 1", in_ready); end
        next_cycle();
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early got out_valid=%b want 0", out_valid); end
            next_cycle();
        end
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hFFFF0000) begin errors++; $display("FAIL lat_data got %h want ffff0000", out_data); end
        next_cycle();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drain got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]       ops [4];
        logic [WIDTH-1:0] expv [4];
        int n = 0;
        int first = -1;
        int last = -1;
        ops[0] = 3'b001; ops[1] = 3'b010; ops[2] = 3'b011; ops[3] = 3'b100;
        expv[0] = 32'hF000F000; expv[1] = 32'hFFF0FFF0; expv[2] = 32'h0FF00FF0; expv[3] = 32'h000F000F;
        out_ready = 1'b1;
        next_cycle();
        for (int c = 0; c < 12; c++) begin
            if (c < 4) begin
                in_valid = 1'b1; in_op = ops[c]; in_a = 32'hF0F0F0F0; in_b = 32'hFF00FF00;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready && n < 4) begin
                checks++;
                if (out_data !== expv[n]) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", n, out_data, expv[n]); end
                if (first < 0) first = c;
                last = c;
                n++;
            end
            next_cycle();
        end
        checks++; if (n !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", n); end
        checks++; if (first !== STAGES) begin errors++; $display("FAIL b2b_first got cycle %0d want %0d", first, STAGES); end
        checks++; if (last - first !== 3) begin errors++; $display("FAIL b2b_spacing got %0d want 3", last - first); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] got [$];
        logic [WIDTH-1:0] hold = '0;
        logic             seen = 1'b0;
        int next = 1;
        int acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1; in_op = 3'b101; in_a = WIDTH'(next); in_b = '1;
            #1;
            if (in_ready) begin acc++; next++; end
            if (out_valid) begin
                if (!seen) begin
                    hold = out_data; seen = 1'b1;
                end else begin
                    checks++;
                    if (out_data !== hold) begin errors++; $display("FAIL bp_stable got %h want %h", out_data, hold); end
                end
            end
            next_cycle();
        end
        #1;
        checks++; if (acc !== STAGES) begin errors++; $display("FAIL bp_accepts got %0d want %0d", acc, STAGES); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_head got %h want 1", out_data); end
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c == 0); in_a = WIDTH'(next);
            #1;
            if (c == 0) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_full_accept got in_ready=%b want 1", in_ready); end
            end
            if (in_valid && in_ready) next++;
            if (out_valid) got.push_back(out_data);
            next_cycle();
        end
        checks++; if (got.size() !== STAGES + 1) begin errors++; $display("FAIL bp_drain_count got %0d want %0d", got.size(), STAGES + 1); end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== WIDTH'(i + 1)) begin errors++; $display("FAIL bp_order[%0d] got %h want %h", i, got[i], WIDTH'(i + 1)); end
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1; in_valid = 1'b1; in_op = 3'b110; in_a = 32'h12345678; in_b = 32'hFFFFFFFF;
        #1;
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL ill_pre got %b want 0", illegal_op); end
        next_cycle();
        in_valid = 1'b0;
        #1;
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_set got %b want 1", illegal_op); end
        for (int i = 1; i < STAGES; i++) next_cycle();
        #1;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ill_data got %h want 0", out_data); end
        next_cycle();
        in_valid = 1'b1; in_op = 3'b001; in_a = 32'hFFFFFFFF; in_b = 32'h0F0F0F0F;
        next_cycle();
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) next_cycle();
        #1;
        checks++; if (out_data !== 32'h0F0F0F0F) begin errors++; $display("FAIL ill_legal_data got %h want 0f0f0f0f", out_data); end
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_sticky got %b want 1", illegal_op); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        logic stale = 1'b0;
        out_ready = 1'b0; in_op = 3'b111; in_a = 32'hDEADBEEF; in_b = '0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            next_cycle();
        end
        #1;
        checks++; if (out_valid !== 1'b1 || illegal_op !== 1'b1) begin errors++; $display("FAIL rm_pre got valid=%b illegal=%b want 1/1", out_valid, illegal_op); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got %b want 0", out_valid); end
        checks++; if (illegal_op !== 1'b0) begin errors++; $display("FAIL rm_illegal got %b want 0", illegal_op); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b want 1", in_ready); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #3 reset_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL rm_stale got out_valid after reset want none"); end
    endtask

`ifdef LOGIC_PIPE_ZERO_FLAG_EN
    task automatic test_zero_flag();
        logic [WIDTH-1:0] gd [$];
        logic             gz [$];
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 2);
            in_op = (c == 0) ? 3'b011 : 3'b000;
            in_a  = (c == 0) ? 32'hA5A5A5A5 : 32'h0;
            in_b  = 32'hA5A5A5A5;
            #1;
            if (out_valid) begin gd.push_back(out_data); gz.push_back(out_zero); end
            next_cycle();
        end
        checks++;
        if (gd.size() !== 2) begin
            errors++; $display("FAIL zf_count got %0d want 2", gd.size());
        end else begin
            checks++; if (gd[0] !== 32'h0 || gz[0] !== 1'b1) begin errors++; $display("FAIL zf_xor got %h/%b want 0/1", gd[0], gz[0]); end
            checks++; if (gd[1] !== 32'hFFFFFFFF || gz[1] !== 1'b0) begin errors++; $display("FAIL zf_not got %h/%b want ffffffff/0", gd[1], gz[1]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_reset_mid();
`ifdef LOGIC_PIPE_ZERO_FLAG_EN
        test_zero_flag();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_pipe.md
Name: logic_pipe

Overview:
- Parametrised, pipelined successor to the single-bit inverter.
- Applies a selectable bitwise operation to WIDTH-bit operands: NOT, AND, OR, XOR, NOR or pass-through.
- Operates through STAGES elastic registered stages with a valid/ready handshake.
- Sits beside the ALU as a stallable logic-op unit feeding writeback.

Parameters:
WIDTH, 32, operand and result width in bits (1..64).
STAGES, 2, pipeline depth in registered stages (1..4).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  input beat present
in_ready  output  1  unit accepts input this cycle
in_op  input  3  operation select
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  result
illegal_op  output  1  sticky flag: an illegal opcode was accepted

Behaviour:
- Reset: the design uses a single clock, clk. reset_n is asynchronous and active-low. While reset_n=0:
  - all stage valid bits = 0;
  - out_valid = 0;
  - out_data = 0;
  - illegal_op = 0;
  - in_ready = 1 (a combinational function of the cleared state).
  - Deassertion takes effect at the first clk edge after reset_n goes high.
- Op encoding:
  - 000 NOT A
  - 001 A AND B
  - 010 A OR B
  - 011 A XOR B
  - 100 NOR (~(A|B))
  - 101 pass A
  - 110 and 111 are illegal: result is all zeros and illegal_op is set.
- Op evaluation:
  - Computed combinationally at the input.
  - Registered into stage 0 together with the valid bit.
  - Stages 1..STAGES-1 copy data and valid only.
- Handshake:
  - A beat transfers on in_valid&in_ready at input, and on out_valid&out_ready at output.
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when out_ready=1 or it is empty.
  - in_ready = stage0 empty OR stage0 advances (combinational from out_ready through the chain; no bubbles).
- Latency and throughput:
  - STAGES cycles from accept to out_valid when out_ready is held 1.
  - Throughput is 1 beat/cycle.
- Full pipeline:
  - All stages valid and out_ready=0 gives in_ready=0.
  - Data holds stable; out_data and out_valid do not change while out_valid=1 and out_ready=0.
- Simultaneous accept and emit when full with out_ready=1:
  - The last stage is emitted and the whole chain shifts.
  - The new beat is accepted the same cycle; occupancy is unchanged.
- Empty-stage data: a stage with valid=0 keeps its old data. out_data is don't-care when out_valid=0 but must not be X after reset.
- illegal_op:
  - Set only on an accepted beat with op 110/111.
  - Stays 1 until reset_n.
- Reset mid-operation: all in-flight beats are discarded and no out_valid is produced for them.
- No in_valid/in_op stability requirement before acceptance; values are sampled only on transfer.

Optional Feature:
- Macro: LOGIC_PIPE_ZERO_FLAG_EN.
- Defined:
  - Adds output port out_zero (1 bit).
  - out_zero = (result == 0), computed at stage 0 and carried alongside data.
  - Valid with out_valid; reset value 0.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1; send op=000 A=0x0000FFFF -> out_valid exactly 2 cycles later, out_data=0xFFFF0000.
- Back-to-back ops 001/010/011/100 with A=0xF0F0F0F0, B=0xFF00FF00, in_valid held 1 -> 4 consecutive results: 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F.
- Backpressure:
  - Hold out_ready=0 and stream beats -> in_ready drops after exactly STAGES accepts; out_data is stable.
  - Release out_ready -> all beats emerge in order with no loss or duplication.
- op=110 with A=0x12345678 -> out_data=0, illegal_op=1 from the cycle after accept; it stays 1 across later legal ops until reset_n=0.
- Assert reset_n=0 asynchronously mid-cycle with 2 beats in flight -> out_valid=0 and illegal_op=0 immediately; no stale result appears after release.
- With LOGIC_PIPE_ZERO_FLAG_EN, STAGES=1: op=011 A=B=0xA5A5A5A5 -> out_data=0, out_zero=1; op=000 A=0 -> out_data=0xFFFFFFFF, out_zero=0.
